// File: rtl/dmi_arbiter_if.sv
// dmi_arbiter_if: handshake bundle between two DMI requesters, the arbiter
// and the shared Debug Module port.
//   req0/req1  : 41-bit requests {addr[40:34], data[33:2], op[1:0]}, valid/ready
//   resp0/resp1: 34-bit responses {data[33:2], resp[1:0]}, valid/ready
//   dmi_req    : shared request toward the Debug Module
//   dmi_resp   : shared response from the Debug Module
// modport slave  : arbiter side
// modport master : requester / Debug Module side (environment)
interface dmi_arbiter_if;
  logic        req0_valid_i, req1_valid_i;
  logic [40:0] req0_i, req1_i;
  logic        req0_ready_o, req1_ready_o;
  logic        resp0_valid_o, resp1_valid_o;
  logic [33:0] resp0_o, resp1_o;
  logic        resp0_ready_i, resp1_ready_i;
  logic        dmi_req_valid_o;
  logic [40:0] dmi_req_o;
  logic        dmi_req_ready_i;
  logic        dmi_resp_valid_i;
  logic [33:0] dmi_resp_i;
  logic        dmi_resp_ready_o;

  modport slave (
    input  req0_valid_i, req1_valid_i, req0_i, req1_i,
    output req0_ready_o, req1_ready_o,
    output resp0_valid_o, resp1_valid_o, resp0_o, resp1_o,
    input  resp0_ready_i, resp1_ready_i,
    output dmi_req_valid_o, dmi_req_o,
    input  dmi_req_ready_i,
    input  dmi_resp_valid_i, dmi_resp_i,
    output dmi_resp_ready_o
  );

  modport master (
    output req0_valid_i, req1_valid_i, req0_i, req1_i,
    input  req0_ready_o, req1_ready_o,
    input  resp0_valid_o, resp1_valid_o, resp0_o, resp1_o,
    output resp0_ready_i, resp1_ready_i,
    input  dmi_req_valid_o, dmi_req_o,
    output dmi_req_ready_i,
    output dmi_resp_valid_i, dmi_resp_i,
    input  dmi_resp_ready_o
  );
endinterface

// File: rtl/dmi_arbiter.sv
// dmi_arbiter: round-robin arbiter letting two requesters (0 = JTAG DTM,
// 1 = host port) share one DMI port, one transaction outstanding at a time.
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset
//   clear_i : synchronous abort of the current transaction (dmireset)
//   bus     : dmi_arbiter_if.slave, requester and Debug Module handshakes
//   busy_o  : high whenever the FSM is not IDLE
//   owner_o : index of the current or most recent grant
// Optional feature: define DMI_ARB_TIMEOUT_EN to add a downstream response
// timeout of TIMEOUT_CYCLES cycles that returns {data=0, resp=FAILED}.
module dmi_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  dmi_arbiter_if.slave bus,
  output logic         busy_o,
  output logic         owner_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, RET} state_t;

  state_t      state, state_nxt;
  logic        owner;
  logic        last_gnt;   // most recent grant; reset to 1 so requester 0 wins the first tie
  logic [40:0] req_reg;
  logic [33:0] resp_reg;

  logic        grant, gnt_idx, resp_take, ret_done, timeout_hit;

`ifdef DMI_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt;

  // cnt holds the number of cycles already spent in the current state, so the
  // TIMEOUT_CYCLES-th cycle in REQ or RESP is the one that leaves for RET.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i)                                  cnt <= '0;
    else if (state_nxt != state)                cnt <= '0;
    else if (state == REQ || state == RESP)     cnt <= cnt + 16'd1;

  always_comb
    timeout_hit = (cnt == TO_LAST) &&
                  ((state == REQ  && !bus.dmi_req_ready_i) ||
                   (state == RESP && !bus.dmi_resp_valid_i));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  // Arbitration: on a tie pick the requester not granted last time.
  always_comb begin
    gnt_idx = 1'b0;
    if (bus.req0_valid_i && bus.req1_valid_i) gnt_idx = ~last_gnt;
    else if (bus.req1_valid_i)                gnt_idx = 1'b1;
  end

  always_comb begin
    grant     = (state == IDLE) && !clear_i && (bus.req0_valid_i || bus.req1_valid_i);
    resp_take = (state == RESP) && bus.dmi_resp_valid_i;
    ret_done  = (state == RET) && (owner ? bus.resp1_ready_i : bus.resp0_ready_i);
  end

  // Next state
  always_comb begin
    state_nxt = state;
    if (clear_i) state_nxt = IDLE;
    else begin
      unique case (state)
        IDLE: if (grant) state_nxt = REQ;
        REQ:  if (bus.dmi_req_ready_i) state_nxt = RESP;
              else if (timeout_hit)    state_nxt = RET;
        RESP: if (resp_take || timeout_hit) state_nxt = RET;
        RET:  if (ret_done) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;

  // Data path registers; clear_i wipes both captured request and response.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      owner    <= 1'b0;
      last_gnt <= 1'b1;
      req_reg  <= '0;
      resp_reg <= '0;
    end else if (clear_i) begin
      req_reg  <= '0;
      resp_reg <= '0;
    end else begin
      if (grant) begin
        req_reg  <= gnt_idx ? bus.req1_i : bus.req0_i;
        owner    <= gnt_idx;
        last_gnt <= gnt_idx;
      end
      if (resp_take)        resp_reg <= bus.dmi_resp_i;
      else if (timeout_hit) resp_reg <= {32'h0, 2'd2};
    end

  // Outputs. Valids are masked by clear_i so an abort wins any handshake in
  // the same cycle. dmi_resp_ready_o stays high in IDLE so stray responses
  // from an aborted transaction are drained and dropped.
  always_comb begin
    bus.req0_ready_o     = grant && !gnt_idx;
    bus.req1_ready_o     = grant &&  gnt_idx;
    bus.dmi_req_valid_o  = (state == REQ) && !clear_i;
    bus.dmi_req_o        = req_reg;
    bus.dmi_resp_ready_o = (state == IDLE) || (state == RESP);
    bus.resp0_valid_o    = (state == RET) && !owner && !clear_i;
    bus.resp1_valid_o    = (state == RET) &&  owner && !clear_i;
    bus.resp0_o          = resp_reg;
    bus.resp1_o          = resp_reg;
    busy_o               = (state != IDLE);
    owner_o              = owner;
  end

endmodule

// File: tb/tb_dmi_arbiter.sv
module tb_dmi_arbiter;
  logic clk = 1'b0;
  logic rst, clear;
  logic busy, owner;
  int   checks = 0;
  int   errors = 0;

  dmi_arbiter_if bus();

  dmi_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (clear),
    .bus     (bus),
    .busy_o  (busy),
    .owner_o (owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [40:0] REQ_A = {7'h10, 32'h0000_0001, 2'd2};  // = 41'h40_0000_0006
  localparam logic [40:0] REQ_B = {7'h22, 32'hCAFE_F00D, 2'd1};
  localparam logic [40:0] REQ_C = {7'h05, 32'h0000_00AA, 2'd1};
  localparam logic [40:0] REQ_D = {7'h11, 32'h1111_2222, 2'd2};

  initial begin
    rst = 1'b1; clear = 1'b0;
    bus.req0_valid_i = 0; bus.req1_valid_i = 0;
    bus.req0_i = '0; bus.req1_i = '0;
    bus.resp0_ready_i = 0; bus.resp1_ready_i = 0;
    bus.dmi_req_ready_i = 0; bus.dmi_resp_valid_i = 0; bus.dmi_resp_i = '0;
    #3;
    // ---- reset state
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_dmi_req_valid", bus.dmi_req_valid_o, 0);
    chk("rst_dmi_resp_ready", bus.dmi_resp_ready_o, 1);
    chk("rst_resp_valids", {bus.resp1_valid_o, bus.resp0_valid_o}, 2'b00);
    chk("rst_dmi_req_data", bus.dmi_req_o, 41'h0);
    step(); rst = 1'b0;

    // ---- single requester, zero-wait DM: resp0 valid in the 4th transaction cycle
    bus.dmi_req_ready_i = 1; bus.dmi_resp_valid_i = 1;
    bus.dmi_resp_i = {32'h1234_5678, 2'd0};
    bus.resp0_ready_i = 1; bus.resp1_ready_i = 1;
    step();
    bus.req0_valid_i = 1; bus.req0_i = REQ_A; #1;
    chk("single_req0_ready", bus.req0_ready_o, 1);
    chk("single_req1_ready", bus.req1_ready_o, 0);
    chk("single_resp0_c1", bus.resp0_valid_o, 0);
    step(); bus.req0_valid_i = 0; #1;
    chk("single_dmi_req_valid", bus.dmi_req_valid_o, 1);
    chk("single_dmi_req_data", bus.dmi_req_o, 41'h40_0000_0006);
    chk("single_owner", owner, 0);
    chk("single_busy", busy, 1);
    chk("single_resp0_c2", bus.resp0_valid_o, 0);
    step(); #1;
    chk("single_resp0_c3", bus.resp0_valid_o, 0);
    step(); #1;
    chk("single_resp0_c4", bus.resp0_valid_o, 1);
    chk("single_resp0_data", bus.resp0_o, {32'h1234_5678, 2'd0});
    chk("single_resp1_valid", bus.resp1_valid_o, 0);
    step(); #1;
    chk("single_idle_busy", busy, 0);
    chk("single_idle_resp0", bus.resp0_valid_o, 0);

    // ---- contention after a fresh reset: grants 0,1,0
    rst = 1'b1; #2; rst = 1'b0;
    step();
    bus.req0_valid_i = 1; bus.req1_valid_i = 1;
    bus.req0_i = REQ_C; bus.req1_i = REQ_D;
    for (int t = 0; t < 3; t++) begin
      logic exp_owner;
      exp_owner = (t == 1);
      #1;
      chk("cont_ready", {bus.req1_ready_o, bus.req0_ready_o}, exp_owner ? 2'b10 : 2'b01);
      step(); #1;
      chk("cont_owner", owner, exp_owner);
      chk("cont_no_ready_in_req", {bus.req1_ready_o, bus.req0_ready_o}, 2'b00);
      chk("cont_dmi_req", bus.dmi_req_o, exp_owner ? REQ_D : REQ_C);
      step(); step(); #1;
      chk("cont_resp_valid", {bus.resp1_valid_o, bus.resp0_valid_o}, exp_owner ? 2'b10 : 2'b01);
      step();
    end
    bus.req0_valid_i = 0; bus.req1_valid_i = 0;

    // ---- backpressure: DM request stall 5 cycles, resp1 stall 3 cycles
    bus.dmi_req_ready_i = 0; bus.dmi_resp_valid_i = 0; bus.resp1_ready_i = 0;
    bus.req1_valid_i = 1; bus.req1_i = REQ_B; #1;
    chk("bp_req1_ready", bus.req1_ready_o, 1);
    step(); bus.req1_valid_i = 0; bus.req1_i = '0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_dmi_req_valid", bus.dmi_req_valid_o, 1);
      chk("bp_dmi_req_stable", bus.dmi_req_o, REQ_B);
      step();
    end
    bus.dmi_req_ready_i = 1;
    step();
    bus.dmi_resp_valid_i = 1; bus.dmi_resp_i = {32'hA5A5_A5A5, 2'd0};
    step(); bus.dmi_resp_valid_i = 0; bus.dmi_resp_i = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_resp1_valid", bus.resp1_valid_o, 1);
      chk("bp_resp1_stable", bus.resp1_o, {32'hA5A5_A5A5, 2'd0});
      chk("bp_resp0_quiet", bus.resp0_valid_o, 0);
      step();
    end
    bus.resp1_ready_i = 1;
    step(); #1;
    chk("bp_idle", busy, 0);
    chk("bp_owner", owner, 1);

    // ---- clear in RESP, late 0xDEADBEEF response is dropped
    bus.req0_valid_i = 1; bus.req0_i = REQ_A;
    step(); bus.req0_valid_i = 0;
    step();                          // now RESP
    clear = 1; #1;
    chk("clr_no_resp_valid", {bus.resp1_valid_o, bus.resp0_valid_o}, 2'b00);
    step(); clear = 0; #1;
    chk("clr_idle", busy, 0);
    bus.dmi_resp_valid_i = 1; bus.dmi_resp_i = {32'hDEAD_BEEF, 2'd0}; #1;
    chk("clr_stray_ready", bus.dmi_resp_ready_o, 1);
    step(); bus.dmi_resp_valid_i = 0; #1;
    chk("clr_stray_dropped", {busy, bus.resp1_valid_o, bus.resp0_valid_o}, 3'b000);
    bus.req0_valid_i = 1; bus.req0_i = REQ_C; #1;
    chk("clr_new_grant", bus.req0_ready_o, 1);
    step(); bus.req0_valid_i = 0;
    step();
    bus.dmi_resp_valid_i = 1; bus.dmi_resp_i = {32'h0000_0055, 2'd0};
    step(); bus.dmi_resp_valid_i = 0; #1;
    chk("clr_next_resp0", bus.resp0_o, {32'h0000_0055, 2'd0});
    step();

    // ---- DM never responds
    bus.req0_valid_i = 1; bus.req0_i = REQ_A;
    step(); bus.req0_valid_i = 0;
    step();                          // first RESP cycle
`ifdef DMI_ARB_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("to_wait_resp0", bus.resp0_valid_o, 0);
      step();
    end
    #1;
    chk("to_resp0_valid", bus.resp0_valid_o, 1);
    chk("to_resp0_data", bus.resp0_o, {32'h0, 2'd2});
    step();
`else
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("nto_busy", busy, 1);
      step();
    end
    clear = 1; step(); clear = 0;
`endif
    #1;
    chk("to_back_idle", busy, 0);

    // ---- async reset during REQ
    bus.dmi_req_ready_i = 0;
    bus.req1_valid_i = 1; bus.req1_i = REQ_B;
    step(); bus.req1_valid_i = 0; #1;
    chk("ar_in_req", bus.dmi_req_valid_o, 1);
    #1; rst = 1; #1;
    chk("ar_busy", busy, 0);
    chk("ar_owner", owner, 0);
    chk("ar_dmi_req_valid", bus.dmi_req_valid_o, 0);
    chk("ar_dmi_req_data", bus.dmi_req_o, 41'h0);
    chk("ar_dmi_resp_ready", bus.dmi_resp_ready_o, 1);
    #1; rst = 0;
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      chk("ar_no_resp", {busy, bus.resp1_valid_o, bus.resp0_valid_o}, 3'b000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
